// File: rtl/cfg_wr_loader.sv
// Streams 32-bit host words into 64-bit RAM entry writes: header, then lo/hi word pairs.
// Optional trailer checksum check is enabled with the CFG_LOADER_CHECKSUM_EN macro.
module cfg_wr_loader #(
    parameter int NUM_RAMS   = 36,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [31:0]           s_data,
    output logic                  s_ready,
    output logic [7:0]            sram_sel,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic                  wr_en,
    output logic [63:0]           din,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  err_clr
);

`ifdef CFG_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LO, HI, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
`endif

    localparam logic [8:0] NUM_RAMS_W = 9'(NUM_RAMS);

    state_t                state_reg, state_next;
    logic [7:0]            sel_reg, sel_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [7:0]            remaining_reg, remaining_next;
    logic [31:0]           lo_reg, lo_next;
    logic                  bad_reg, bad_next;
    logic                  wr_en_reg, wr_en_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next, err_set;
    logic [7:0]            sram_sel_reg, sram_sel_next;
    logic [ADDR_WIDTH-1:0] addr_wr_reg, addr_wr_next;
    logic [63:0]           din_reg, din_next;
    logic [6:0]            hdr_addr;
`ifdef CFG_LOADER_CHECKSUM_EN
    logic [31:0]           csum_reg, csum_next;
`endif

    // The loader never stalls the host, so every valid word is a handshake.
    assign s_ready  = 1'b1;
    assign hdr_addr = s_data[22:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (s_valid) begin
            case (state_reg)
                IDLE:    state_next = (s_data[7:0] == 8'd0) ? IDLE : LO;
                LO:      state_next = HI;
`ifdef CFG_LOADER_CHECKSUM_EN
                HI:      state_next = (remaining_reg == 8'd1) ? CHK : LO;
                CHK:     state_next = IDLE;
`else
                HI:      state_next = (remaining_reg == 8'd1) ? IDLE : LO;
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        sel_next       = sel_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        lo_next        = lo_reg;
        bad_next       = bad_reg;
        wr_en_next     = 1'b0;
        done_next      = 1'b0;
        err_set        = 1'b0;
        sram_sel_next  = sram_sel_reg;
        addr_wr_next   = addr_wr_reg;
        din_next       = din_reg;
`ifdef CFG_LOADER_CHECKSUM_EN
        csum_next      = csum_reg;
`endif
        if (s_valid) begin
            case (state_reg)
                IDLE: begin
                    sel_next       = s_data[31:24];
                    addr_next      = ADDR_WIDTH'(hdr_addr);
                    remaining_next = s_data[7:0];
                    bad_next       = ({1'b0, s_data[31:24]} >= NUM_RAMS_W);
                    err_set        = ({1'b0, s_data[31:24]} >= NUM_RAMS_W);
                    done_next      = (s_data[7:0] == 8'd0);
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_next      = 32'd0;
`endif
                end
                LO: begin
                    lo_next = s_data;
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_next = csum_reg ^ s_data;
`endif
                end
                HI: begin
                    // Out-of-range targets still walk the address so the word stream stays aligned.
                    if (!bad_reg) begin
                        wr_en_next    = 1'b1;
                        din_next      = {s_data, lo_reg};
                        addr_wr_next  = addr_reg;
                        sram_sel_next = sel_reg;
                    end
                    addr_next      = addr_reg + ADDR_WIDTH'(1);
                    remaining_next = remaining_reg - 8'd1;
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_next = csum_reg ^ s_data;
`else
                    done_next = (remaining_reg == 8'd1);
`endif
                end
`ifdef CFG_LOADER_CHECKSUM_EN
                CHK: begin
                    done_next = 1'b1;
                    err_set   = (s_data != csum_reg);
                end
`endif
                default: ;
            endcase
        end
        err_next = err_set | (err_reg & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg       <= '0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            lo_reg        <= '0;
            bad_reg       <= 1'b0;
            wr_en_reg     <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            sram_sel_reg  <= '0;
            addr_wr_reg   <= '0;
            din_reg       <= '0;
`ifdef CFG_LOADER_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            sel_reg       <= sel_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            lo_reg        <= lo_next;
            bad_reg       <= bad_next;
            wr_en_reg     <= wr_en_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            sram_sel_reg  <= sram_sel_next;
            addr_wr_reg   <= addr_wr_next;
            din_reg       <= din_next;
`ifdef CFG_LOADER_CHECKSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    assign busy     = (state_reg != IDLE);
    assign wr_en    = wr_en_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign sram_sel = sram_sel_reg;
    assign addr_wr  = addr_wr_reg;
    assign din      = din_reg;

endmodule

// File: tb/tb_cfg_wr_loader.sv
// Directed bench for cfg_wr_loader: back-to-back, wrap, bad target, reset abort, gapped input.
module tb_cfg_wr_loader;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic [7:0]    sram_sel;
    logic [AW-1:0] addr_wr;
    logic          wr_en;
    logic [63:0]   din;
    logic          busy;
    logic          done;
    logic          err;
    logic          err_clr;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'hAAAA_0001;
    localparam logic [31:0] B0 = 32'h2222_0002, B1 = 32'hBBBB_0003;
    localparam logic [31:0] C0 = 32'h3333_0004, C1 = 32'hCCCC_0005;
    localparam logic [31:0] D0 = 32'h4444_0006, D1 = 32'hDDDD_0007;
    localparam logic [31:0] E0 = 32'h5555_0008, E1 = 32'hEEEE_0009;
    localparam logic [31:0] F0 = 32'h6666_000A;
    localparam logic [31:0] G0 = 32'h7777_000B, G1 = 32'h9999_000C;

    cfg_wr_loader #(.NUM_RAMS(36), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .sram_sel (sram_sel),
        .addr_wr  (addr_wr),
        .wr_en    (wr_en),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word for one cycle after `gap` idle cycles; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] w, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = w;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Closes a command right after its final data word.
    task automatic end_cmd(input string tag, input logic [31:0] trailer);
`ifdef CFG_LOADER_CHECKSUM_EN
        check({tag, "_chk_busy"}, 64'(busy), 64'd1);
        check({tag, "_chk_nodone"}, 64'(done), 64'd0);
        send(trailer, 0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_trl_nowr"}, 64'(wr_en), 64'd0);
`else
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_trailer_unused"}, 64'(trailer != 32'hFFFF_FFFF), 64'd1);
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        err_clr = 1'b0;
        idle_cycle();
        idle_cycle();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_sel", 64'(sram_sel), 64'd0);
        check("rst_addr", 64'(addr_wr), 64'd0);
        check("rst_din", din, 64'd0);
        check("rst_ready", 64'(s_ready), 64'd1);
        rst_n = 1'b1;
        idle_cycle();

        // Back-to-back two-entry command at sel 3 addr 5
        send(32'h0305_0002, 0);
        check("b2b_hdr_busy", 64'(busy), 64'd1);
        check("b2b_hdr_nowr", 64'(wr_en), 64'd0);
        send(A0, 0);
        check("b2b_lo_nowr", 64'(wr_en), 64'd0);
        send(A1, 0);
        check("b2b_wr1", 64'(wr_en), 64'd1);
        check("b2b_sel1", 64'(sram_sel), 64'd3);
        check("b2b_addr1", 64'(addr_wr), 64'd5);
        check("b2b_din1", din, {A1, A0});
        check("b2b_nodone1", 64'(done), 64'd0);
        send(B0, 0);
        check("b2b_gap_nowr", 64'(wr_en), 64'd0);
        check("b2b_hold_addr", 64'(addr_wr), 64'd5);
        check("b2b_hold_din", din, {A1, A0});
        send(B1, 0);
        check("b2b_wr2", 64'(wr_en), 64'd1);
        check("b2b_addr2", 64'(addr_wr), 64'd6);
        check("b2b_din2", din, {B1, B0});
        end_cmd("b2b", A0 ^ A1 ^ B0 ^ B1);
        idle_cycle();
        check("b2b_after_nowr", 64'(wr_en), 64'd0);
        check("b2b_after_nodone", 64'(done), 64'd0);
        check("b2b_after_idle", 64'(busy), 64'd0);
        check("b2b_after_err", 64'(err), 64'd0);

        // Address wrap 127 -> 0
        send(32'h017F_0002, 0);
        send(C0, 0);
        send(C1, 0);
        check("wrap_wr1", 64'(wr_en), 64'd1);
        check("wrap_sel", 64'(sram_sel), 64'd1);
        check("wrap_addr1", 64'(addr_wr), 64'd127);
        check("wrap_din1", din, {C1, C0});
        send(D0, 0);
        send(D1, 0);
        check("wrap_wr2", 64'(wr_en), 64'd1);
        check("wrap_addr2", 64'(addr_wr), 64'd0);
        check("wrap_din2", din, {D1, D0});
        end_cmd("wrap", C0 ^ C1 ^ D0 ^ D1);
        idle_cycle();

        // Out-of-range target: words consumed, no write, err sticky until cleared
        send(32'h2800_0001, 0);
        check("bad_err", 64'(err), 64'd1);
        check("bad_busy", 64'(busy), 64'd1);
        send(E0, 0);
        send(E1, 0);
        check("bad_nowr", 64'(wr_en), 64'd0);
        check("bad_hold_sel", 64'(sram_sel), 64'd1);
        check("bad_hold_din", din, {D1, D0});
        end_cmd("bad", E0 ^ E1);
        check("bad_err_sticky", 64'(err), 64'd1);
        err_clr = 1'b1;
        idle_cycle();
        err_clr = 1'b0;
        check("bad_err_clr", 64'(err), 64'd0);

        // Zero-count bad header with err_clr in the same cycle: set wins, done next cycle
        err_clr = 1'b1;
        send(32'h2800_0000, 0);
        err_clr = 1'b0;
        check("zero_err_set_wins", 64'(err), 64'd1);
        check("zero_done", 64'(done), 64'd1);
        check("zero_idle", 64'(busy), 64'd0);
        check("zero_nowr", 64'(wr_en), 64'd0);
        idle_cycle();
        check("zero_done_pulse", 64'(done), 64'd0);
        check("zero_err_held", 64'(err), 64'd1);
        err_clr = 1'b1;
        idle_cycle();
        err_clr = 1'b0;
        check("zero_err_clr", 64'(err), 64'd0);

        // Reset after a LO word abandons the command
        send(32'h0210_0003, 0);
        send(F0, 0);
        check("abort_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy_rst", 64'(busy), 64'd0);
        check("abort_sel_rst", 64'(sram_sel), 64'd0);
        check("abort_din_rst", din, 64'd0);
        idle_cycle();
        rst_n = 1'b1;
        send(32'h0410_0001, 0);
        check("abort_hdr_nowr", 64'(wr_en), 64'd0);
        send(G0, 0);
        send(G1, 0);
        check("abort_wr", 64'(wr_en), 64'd1);
        check("abort_sel", 64'(sram_sel), 64'd4);
        check("abort_addr", 64'(addr_wr), 64'd16);
        check("abort_din", din, {G1, G0});
        end_cmd("abort", G0 ^ G1);
        idle_cycle();

        // Gapped input reproduces the back-to-back write sequence
        send(32'h0305_0002, int'($urandom_range(0, 3)));
        send(A0, int'($urandom_range(0, 3)));
        send(A1, int'($urandom_range(0, 3)));
        check("gap_wr1", 64'(wr_en), 64'd1);
        check("gap_sel1", 64'(sram_sel), 64'd3);
        check("gap_addr1", 64'(addr_wr), 64'd5);
        check("gap_din1", din, {A1, A0});
        send(B0, int'($urandom_range(0, 3)));
        send(B1, int'($urandom_range(0, 3)));
        check("gap_wr2", 64'(wr_en), 64'd1);
        check("gap_addr2", 64'(addr_wr), 64'd6);
        check("gap_din2", din, {B1, B0});
        end_cmd("gap", A0 ^ A1 ^ B0 ^ B1);
        check("gap_err", 64'(err), 64'd0);
        idle_cycle();

`ifdef CFG_LOADER_CHECKSUM_EN
        // Corrupted trailer flags err but the write already happened
        send(32'h0500_0001, 0);
        send(C0, 0);
        send(C1, 0);
        check("csum_wr", 64'(wr_en), 64'd1);
        check("csum_din", din, {C1, C0});
        send(C0 ^ C1 ^ 32'h1, 0);
        check("csum_done", 64'(done), 64'd1);
        check("csum_err", 64'(err), 64'd1);
        idle_cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cfg_wr_loader.md
CFG_WR_LOADER -- requirements
Module: cfg_wr_loader

Interface
REQ-001 Parameter NUM_RAMS, default 36, number of valid sram_sel targets (0..NUM_RAMS-1).
REQ-002 Parameter ADDR_WIDTH, default 7, width of addr_wr.
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port s_valid  input  1  host word valid.
REQ-006 Port s_data  input  32  host word.
REQ-007 Port s_ready  output  1  loader accepts s_data when s_valid & s_ready.
REQ-008 Port sram_sel  output  8  target RAM index.
REQ-009 Port addr_wr  output  ADDR_WIDTH  target entry address.
REQ-010 Port wr_en  output  1  one-cycle write strobe.
REQ-011 Port din  output  64  write data.
REQ-012 Port busy  output  1  high whenever state != IDLE.
REQ-013 Port done  output  1  one-cycle pulse at end of command.
REQ-014 Port err  output  1  sticky error flag.
REQ-015 Port err_clr  input  1  clears err.

Function
REQ-016 The FSM SHALL have the states IDLE, LO, HI and CHK, with s_ready=1 in every state.
REQ-017 An IDLE handshake SHALL decode the header as sel=s_data[31:24], start addr=s_data[22:16] (truncated to ADDR_WIDTH), count=s_data[7:0] 64-bit entries; the transition is IDLE->LO.
REQ-018 A header with count=0 SHALL pulse done in the next cycle, issue no write, and return to IDLE (CHK state skipped).
REQ-019 A LO handshake SHALL latch s_data as din[31:0]; the transition is LO->HI.
REQ-020 A HI handshake SHALL, in the following cycle, assert wr_en for exactly one cycle with din={hi,lo}, addr_wr=current address and sram_sel=sel.
REQ-021 After each entry the address SHALL increment modulo 2^ADDR_WIDTH (127 wraps to 0) and remaining SHALL decrement; remaining>0 -> LO, remaining=0 -> IDLE (or CHK, see REQ-029).
REQ-022 Sustained throughput SHALL be one entry per two accepted words, with no bubble between entries.
REQ-023 When wr_en=0, sram_sel, addr_wr and din SHALL hold their last values.
REQ-024 A header with sel>=NUM_RAMS SHALL set err; its data words are still consumed with wr_en suppressed, and done still pulses.
REQ-025 If err_clr and an error-set event occur in the same cycle, set SHALL win.
REQ-026 Without CHK, done SHALL pulse in the same cycle as the final wr_en.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, wr_en=0, done=0, err=0, busy=0, sram_sel=0, addr_wr=0, din=0 and clear the internal counters.
REQ-028 Reset mid-command SHALL abandon the command; after release, the next accepted word is treated as a header.

Configuration
REQ-029 With CFG_LOADER_CHECKSUM_EN defined, after the last entry the FSM SHALL enter CHK and accept one trailer word; done pulses the cycle after that handshake, and err is set if the trailer != XOR of all data words of the command (lo and hi). Writes are not rolled back.
REQ-030 Without CFG_LOADER_CHECKSUM_EN, the CHK state and checksum logic SHALL be absent and no trailer word is expected.

Verification
REQ-031 Header 0x0305_0002 + words A0,A1,B0,B1 back-to-back -> wr_en at sel=3 addr=5 din={A1,A0}, then addr=6 din={B1,B0} two cycles later; done with second wr_en.
REQ-032 Header sel=1 addr=127 count=2 -> writes to addr 127 then addr 0.
REQ-033 Header sel=40 (>=36) count=1 + 2 data words -> no wr_en, err=1, done pulse; err_clr -> err=0.
REQ-034 rst_n low after LO word accepted -> outputs reset immediately; new header after release decoded correctly.
REQ-035 s_valid gapped randomly between words -> identical write sequence as REQ-031.
REQ-036 With CFG_LOADER_CHECKSUM_EN: correct trailer -> err=0; corrupted trailer -> err=1, writes still performed.
